// File: rtl/info_banner_scheduler_pkg.sv
// info_banner_scheduler_pkg: banner message/state types, position table and sticky rule
package info_banner_scheduler_pkg;
   typedef enum logic [1:0] {WELCOME, LEVEL_UP, PAUSE, GAME_OVER} msg_t;
   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
   // {X, Y} top-left corner of each banner bitmap, indexed by msg_t
   localparam logic [21:0] BANNER_POS [4] = '{
      {11'd170, 11'd10}, {11'd260, 11'd200}, {11'd280, 11'd220}, {11'd240, 11'd200}};
   function automatic logic is_sticky(msg_t m);
      return m == GAME_OVER;
   endfunction
endpackage

// File: rtl/info_banner_scheduler_if.sv
// info_banner_scheduler_if: game-control <-> banner scheduler signals
// master = game FSM side (frame strobe, requests, cancel), slave = scheduler side (banner outputs, status)
interface info_banner_scheduler_if;
   import info_banner_scheduler_pkg::*;
   logic        startOfFrame, req_valid, req_ready, cancel, banner_enable, busy, done;
   msg_t        req_msg, banner_msg;
   logic [10:0] banner_topLeftX, banner_topLeftY;
   modport master (output startOfFrame, req_valid, req_msg, cancel,
                   input  req_ready, banner_enable, banner_msg, banner_topLeftX, banner_topLeftY, busy, done);
   modport slave  (input  startOfFrame, req_valid, req_msg, cancel,
                   output req_ready, banner_enable, banner_msg, banner_topLeftX, banner_topLeftY, busy, done);
endinterface

// File: rtl/info_banner_scheduler_fifo.sv
// info_banner_scheduler_fifo: power-of-2 FIFO of pending banner requests
// Ports: clk, resetN (sync, active low), flush, push/din, pop/dout (show-ahead), full, empty
module info_banner_scheduler_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0] r_cnt;
   logic w_wr, w_rd;
   assign full  = r_cnt == (AW+1)'(DEPTH);
   assign empty = r_cnt == '0;
   assign dout  = r_mem[r_rp];
   // a push while full is rejected even if a pop frees a slot in the same cycle
   assign w_wr  = push && !full && !flush;
   assign w_rd  = pop && !empty && !flush;
   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wp] <= din;
   always_ff @(posedge clk)
      if (!resetN || flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= r_wp + AW'(w_wr);
         r_rp  <= r_rp + AW'(w_rd);
         r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      end
endmodule

// File: rtl/info_banner_scheduler.sv
// info_banner_scheduler: queues banner requests and shows each for a fixed frame count with optional blink
// Ports: clk, resetN (sync, active low), bus (slave): startOfFrame/req/cancel in;
//        banner_enable/msg/topLeftX/topLeftY, req_ready, busy, done out
module info_banner_scheduler
   import info_banner_scheduler_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int SHOW_FRAMES  = 120,
   parameter int BLINK_FRAMES = 15,
   parameter int GAP_FRAMES   = 30
) (
   input logic clk,
   input logic resetN,
   info_banner_scheduler_if.slave bus
);
   localparam int SHOW_N = SHOW_FRAMES == 0 ? 1 : SHOW_FRAMES;
   localparam int CMAX = SHOW_N > GAP_FRAMES ? SHOW_N : GAP_FRAMES;
   localparam int CW = $clog2(CMAX + 1);
   localparam int BW = BLINK_FRAMES < 2 ? 1 : $clog2(BLINK_FRAMES);
   localparam logic [CW-1:0] SHOW_M1 = CW'(SHOW_N - 1);
   localparam logic [CW-1:0] GAP_M1 = CW'(GAP_FRAMES == 0 ? 0 : GAP_FRAMES - 1);
   localparam logic [BW-1:0] BLINK_M1 = BW'(BLINK_FRAMES == 0 ? 0 : BLINK_FRAMES - 1);
   state_t r_state, w_state_n;
   logic [CW-1:0] r_frame, w_frame_n;
   logic [BW-1:0] r_blink, w_blink_n;
   logic r_phase, w_phase_n, r_en, w_en_n, r_done, w_done_n;
   msg_t r_msg, w_msg_n, w_head;
   logic [10:0] r_x, r_y, w_x_n, w_y_n;
   logic [1:0] w_dout;
   logic w_push, w_pop, w_full, w_empty;
   assign w_push = bus.req_valid && !bus.cancel;
   assign w_head = msg_t'(w_dout);
   info_banner_scheduler_fifo #(.DEPTH(FIFO_DEPTH), .W(2)) u_fifo (
      .clk(clk), .resetN(resetN), .flush(bus.cancel), .push(w_push), .pop(w_pop),
      .din(bus.req_msg), .dout(w_dout), .full(w_full), .empty(w_empty));
   always_comb begin
      w_pop = 1'b0;
      w_state_n = r_state;
      w_frame_n = r_frame;
      w_blink_n = r_blink;
      w_phase_n = r_phase;
      w_en_n = r_en;
      w_done_n = 1'b0;
      w_msg_n = r_msg;
      {w_x_n, w_y_n} = {r_x, r_y};
      if (bus.cancel) begin
         w_state_n = IDLE;
         w_frame_n = '0;
         w_blink_n = '0;
         w_en_n = 1'b0;
      end else
         unique case (r_state)
            IDLE:
               if (!w_empty) begin
                  w_pop = 1'b1;
                  w_msg_n = w_head;
                  {w_x_n, w_y_n} = BANNER_POS[w_head];
                  w_frame_n = '0;
                  w_blink_n = '0;
                  w_phase_n = 1'b1;
                  w_en_n = 1'b1;
                  w_state_n = SHOW;
               end
            SHOW:
               if (bus.startOfFrame) begin
                  if (!is_sticky(r_msg) && r_frame == SHOW_M1) begin
                     w_state_n = GAP_FRAMES == 0 ? IDLE : GAP;
                     w_frame_n = '0;
                     w_en_n = 1'b0;
                     w_done_n = 1'b1;
                  end else begin
                     // saturate so a sticky banner never wraps the counter
                     w_frame_n = r_frame == SHOW_M1 ? r_frame : r_frame + 1'b1;
                     if (BLINK_FRAMES > 0 && r_blink == BLINK_M1) begin
                        w_phase_n = !r_phase;
                        w_blink_n = '0;
                     end else
                        w_blink_n = r_blink + 1'b1;
                     w_en_n = w_phase_n;
                  end
               end
            GAP:
               if (bus.startOfFrame) begin
                  w_state_n = r_frame == GAP_M1 ? IDLE : GAP;
                  w_frame_n = r_frame == GAP_M1 ? '0 : r_frame + 1'b1;
               end
            default: w_state_n = IDLE;
         endcase
   end
   always_ff @(posedge clk)
      if (!resetN) begin
         r_state <= IDLE;
         r_frame <= '0;
         r_blink <= '0;
         r_phase <= 1'b0;
         r_en <= 1'b0;
         r_done <= 1'b0;
         r_msg <= WELCOME;
         {r_x, r_y} <= BANNER_POS[WELCOME];
      end else begin
         r_state <= w_state_n;
         r_frame <= w_frame_n;
         r_blink <= w_blink_n;
         r_phase <= w_phase_n;
         r_en <= w_en_n;
         r_done <= w_done_n;
         r_msg <= w_msg_n;
         {r_x, r_y} <= {w_x_n, w_y_n};
      end
   assign bus.banner_enable = r_en;
   assign bus.banner_msg = r_msg;
   assign bus.banner_topLeftX = r_x;
   assign bus.banner_topLeftY = r_y;
   assign bus.done = r_done;
   assign bus.req_ready = !w_full;
   assign bus.busy = r_state != IDLE || !w_empty;
endmodule

// File: tb/tb_info_banner_scheduler.sv
// tb_info_banner_scheduler: default and fast-config schedulers driven in parallel against a queue-based model
module tb_info_banner_scheduler;
   import info_banner_scheduler_pkg::*;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   info_banner_scheduler_if ifa ();
   info_banner_scheduler_if ifb ();
   info_banner_scheduler dut_a (.clk(clk), .resetN(rst_n), .bus(ifa.slave));
   info_banner_scheduler #(.FIFO_DEPTH(4), .SHOW_FRAMES(1), .BLINK_FRAMES(0), .GAP_FRAMES(0))
      dut_b (.clk(clk), .resetN(rst_n), .bus(ifb.slave));
   assign ifb.startOfFrame = ifa.startOfFrame;
   assign ifb.req_valid = ifa.req_valid;
   assign ifb.req_msg = ifa.req_msg;
   assign ifb.cancel = ifa.cancel;
   int n_total = 0, n_bad = 0;
   bit mon_on = 1'b0;
   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic int pos_x(msg_t m);
      return m == WELCOME ? 170 : m == LEVEL_UP ? 260 : m == PAUSE ? 280 : 240;
   endfunction
   function automatic int pos_y(msg_t m);
      return m == WELCOME ? 10 : m == LEVEL_UP ? 200 : m == PAUSE ? 220 : 200;
   endfunction
   // model: mode 0 idle / 1 showing / 2 gap; fr = frames elapsed in the current mode
   int P_SHOW [2] = '{120, 1};
   int P_BLINK [2] = '{15, 0};
   int P_GAP [2] = '{30, 0};
   msg_t mq [2][$];
   int mode [2], fr [2];
   bit e_en [2], e_done [2];
   msg_t e_msg [2];
   task automatic step(input int k);
      bit full;
      full = mq[k].size() == 4;
      if (!rst_n) begin
         mq[k].delete();
         mode[k] = 0; fr[k] = 0; e_en[k] = 0; e_done[k] = 0; e_msg[k] = WELCOME;
      end else begin
         e_done[k] = 0;
         if (ifa.cancel) begin
            mq[k].delete();
            mode[k] = 0; fr[k] = 0; e_en[k] = 0;
         end else begin
            if (mode[k] == 0) begin
               if (mq[k].size() > 0) begin
                  e_msg[k] = mq[k].pop_front();
                  mode[k] = 1; fr[k] = 0; e_en[k] = 1;
               end
            end else if (ifa.startOfFrame) begin
               fr[k]++;
               if (mode[k] == 1) begin
                  if (e_msg[k] != GAME_OVER && fr[k] == P_SHOW[k]) begin
                     e_done[k] = 1; e_en[k] = 0; fr[k] = 0;
                     mode[k] = P_GAP[k] == 0 ? 0 : 2;
                  end else
                     e_en[k] = P_BLINK[k] == 0 || (fr[k] / P_BLINK[k]) % 2 == 0;
               end else if (fr[k] == P_GAP[k]) begin
                  mode[k] = 0; fr[k] = 0;
               end
            end
            if (ifa.req_valid && !full) mq[k].push_back(ifa.req_msg);
         end
      end
   endtask
   always @(posedge clk) for (int k = 0; k < 2; k++) step(k);
   always @(negedge clk) if (mon_on) begin
      chk("a_en", ifa.banner_enable, e_en[0]);
      chk("a_msg", ifa.banner_msg, e_msg[0]);
      chk("a_x", ifa.banner_topLeftX, pos_x(e_msg[0]));
      chk("a_y", ifa.banner_topLeftY, pos_y(e_msg[0]));
      chk("a_done", ifa.done, e_done[0]);
      chk("a_ready", ifa.req_ready, mq[0].size() < 4);
      chk("a_busy", ifa.busy, mode[0] != 0 || mq[0].size() > 0);
      chk("b_en", ifb.banner_enable, e_en[1]);
      chk("b_msg", ifb.banner_msg, e_msg[1]);
      chk("b_x", ifb.banner_topLeftX, pos_x(e_msg[1]));
      chk("b_y", ifb.banner_topLeftY, pos_y(e_msg[1]));
      chk("b_done", ifb.done, e_done[1]);
      chk("b_ready", ifb.req_ready, mq[1].size() < 4);
      chk("b_busy", ifb.busy, mode[1] != 0 || mq[1].size() > 0);
   end
   task automatic tick(input bit sof, input bit rv, input msg_t m, input bit cx);
      ifa.startOfFrame = sof;
      ifa.req_valid = rv;
      ifa.req_msg = m;
      ifa.cancel = cx;
      @(negedge clk);
   endtask
   task automatic wait_done(input int budget, output msg_t m, output int sofs);
      bit s;
      sofs = 0;
      m = WELCOME;
      for (int i = 0; i < budget; i++) begin
         s = 1'($urandom_range(0, 1));
         tick(s, 0, WELCOME, 0);
         sofs += int'(s);
         if (ifa.done) begin
            m = ifa.banner_msg;
            return;
         end
      end
      chk("timeout_done", 0, 1);
   endtask
   task automatic wait_idle(input int budget, output int sofs);
      bit s;
      sofs = 0;
      for (int i = 0; i < budget; i++) begin
         s = 1'($urandom_range(0, 1));
         tick(s, 0, WELCOME, 0);
         sofs += int'(s);
         if (!ifa.busy) return;
      end
      chk("timeout_idle", 0, 1);
   endtask
   task automatic chk_reset_a(input string tag);
      chk({tag, "_en"}, ifa.banner_enable, 0);
      chk({tag, "_msg"}, ifa.banner_msg, 0);
      chk({tag, "_x"}, ifa.banner_topLeftX, 170);
      chk({tag, "_y"}, ifa.banner_topLeftY, 10);
      chk({tag, "_done"}, ifa.done, 0);
      chk({tag, "_ready"}, ifa.req_ready, 1);
      chk({tag, "_busy"}, ifa.busy, 0);
   endtask
   msg_t seq [5] = '{LEVEL_UP, PAUSE, WELCOME, LEVEL_UP, GAME_OVER};
   msg_t exp_order [5] = '{PAUSE, LEVEL_UP, PAUSE, WELCOME, LEVEL_UP};
   initial begin
      msg_t m;
      int sofs, ndone;
      rst_n = 1'b0;
      ifa.startOfFrame = 0; ifa.req_valid = 0; ifa.req_msg = WELCOME; ifa.cancel = 0;
      repeat (3) @(negedge clk);
      mon_on = 1'b1;
      chk_reset_a("rst");
      rst_n = 1'b1;
      // single WELCOME: visible two cycles after request, 120 frames shown, 30 frame gap
      tick(0, 1, WELCOME, 0);
      tick(0, 0, WELCOME, 0);
      chk("t1_en", ifa.banner_enable, 1);
      chk("t1_x", ifa.banner_topLeftX, 170);
      chk("t1_y", ifa.banner_topLeftY, 10);
      wait_done(2000, m, sofs);
      chk("t1_show_frames", sofs, 120);
      wait_idle(2000, sofs);
      chk("t1_gap_frames", sofs, 30);
      // five back-to-back pushes while showing: fifth dropped, four shown in order
      tick(0, 1, PAUSE, 0);
      tick(0, 0, WELCOME, 0);
      for (int i = 0; i < 5; i++) begin
         tick(0, 1, seq[i], 0);
         if (i == 2) chk("t2_ready3", ifa.req_ready, 1);
         if (i == 3) chk("t2_ready4", ifa.req_ready, 0);
      end
      for (int i = 0; i < 5; i++) begin
         wait_done(1500, m, sofs);
         chk("t2_order", m, exp_order[i]);
      end
      wait_idle(2000, sofs);
      // sticky GAME_OVER then cancel
      tick(0, 1, GAME_OVER, 0);
      tick(0, 1, LEVEL_UP, 0);
      ndone = 0;
      for (int i = 0; i < 510; i++) begin
         tick(1, 0, WELCOME, 0);
         ndone += int'(ifa.done);
      end
      chk("t3_no_done", ndone, 0);
      chk("t3_busy", ifa.busy, 1);
      chk("t3_msg", ifa.banner_msg, GAME_OVER);
      tick(0, 0, WELCOME, 1);
      chk("t3_cancel_en", ifa.banner_enable, 0);
      chk("t3_cancel_busy", ifa.busy, 0);
      repeat (40) tick(1'($urandom_range(0, 1)), 0, WELCOME, 0);
      chk("t3_discard_en", ifa.banner_enable, 0);
      chk("t3_discard_busy", ifa.busy, 0);
      // fast config: one-frame show, done one cycle, next item popped the cycle after
      tick(0, 1, WELCOME, 0);
      tick(0, 1, PAUSE, 0);
      chk("t4_en", ifb.banner_enable, 1);
      chk("t4_msg", ifb.banner_msg, WELCOME);
      tick(1, 0, WELCOME, 0);
      chk("t4_done", ifb.done, 1);
      chk("t4_off", ifb.banner_enable, 0);
      tick(0, 0, WELCOME, 0);
      chk("t4_done_1cyc", ifb.done, 0);
      chk("t4_next_en", ifb.banner_enable, 1);
      chk("t4_next_msg", ifb.banner_msg, PAUSE);
      tick(0, 0, WELCOME, 1);
      // reset mid-show with two queued requests
      tick(0, 1, WELCOME, 0);
      tick(0, 1, LEVEL_UP, 0);
      tick(0, 1, PAUSE, 0);
      repeat (5) tick(1, 0, WELCOME, 0);
      rst_n = 1'b0;
      tick(0, 0, WELCOME, 0);
      chk_reset_a("t5");
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1'($urandom_range(0, 1)), 0, WELCOME, 0);
         ndone += int'(ifa.done);
      end
      chk("t5_no_done", ndone, 0);
      chk("t5_busy", ifa.busy, 0);
      // request together with cancel is ignored; push+pop keeps count and order
      tick(0, 1, PAUSE, 1);
      chk("t6_cx_busy", ifa.busy, 0);
      tick(0, 0, WELCOME, 0);
      tick(0, 0, WELCOME, 0);
      chk("t6_cx_en", ifa.banner_enable, 0);
      tick(0, 1, WELCOME, 0);
      tick(0, 1, LEVEL_UP, 0);
      chk("t6_pp_msg", ifa.banner_msg, WELCOME);
      chk("t6_pp_busy", ifa.busy, 1);
      wait_done(1500, m, sofs);
      chk("t6_first", m, WELCOME);
      wait_done(1500, m, sofs);
      chk("t6_second", m, LEVEL_UP);
      wait_idle(2000, sofs);
      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst_n = $urandom_range(0, 399) != 0;
         tick(1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
              msg_t'(2'($urandom_range(0, 3))), $urandom_range(0, 149) == 0);
      end
      rst_n = 1'b1;
      tick(0, 0, WELCOME, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
